lc3_mem_initiator: RTL
======================

Name: lc3_mem_initiator

Overview:
Bus-master front end that turns single CPU load/store requests into the enable/address/data strobes the block-RAM memory expects. It waits for the memory's ready bit, captures read data, and returns a one-cycle response to the CPU datapath (MAR/MDR side). It sits between the LC3 control unit and the memory instance. It adds a bounded timeout so a non-responding memory cannot hang the CPU.

Parameters:
AddrBusSize, 16, width of request and memory address buses
ElementSize, 16, width of data words
TimeoutCycles, 8, maximum WAIT cycles before an error response (>=2)
TimeoutWidth, 4, counter width; must hold TimeoutCycles-1

Ports:
i_CLK  input  1  system clock, all state on rising edge
i_RST  input  1  asynchronous, active-high reset
i_req_valid  input  1  CPU request present
o_req_ready  output  1  initiator idle and able to accept
i_req_write  input  1  1 = store, 0 = load
i_req_addr  input  AddrBusSize  request address
i_req_wdata  input  ElementSize  store data
o_resp_valid  output  1  one-cycle response strobe
o_resp_rdata  output  ElementSize  load data; 0 for stores and errors
o_resp_err  output  1  timeout flag, qualified by o_resp_valid
o_mem_write_en  output  1  to memory write enable
o_mem_read_en  output  1  to memory read enable
o_mem_write_addr  output  AddrBusSize  to memory write address
o_mem_read_addr  output  AddrBusSize  to memory read address
o_mem_write_data  output  ElementSize  to memory write data
i_mem_ready  input  1  memory ready bit
i_mem_read_data  input  ElementSize  memory read data

Behaviour:
- All outputs are registered except o_req_ready. o_req_ready = (state==IDLE).
- Reset (async, any time) forces state IDLE. It sets o_mem_write_en = o_mem_read_en = o_resp_valid = o_resp_err = 0. Addresses, write data, rdata and the timeout counter go to 0.
- States: IDLE, ISSUE, WAIT, RESP (2-bit encoding).
- IDLE: on an edge with i_req_valid=1, latch addr, wdata and write. Both o_mem_*_addr are driven from the latched address. Go to ISSUE.
- ISSUE: exactly one of o_mem_write_en / o_mem_read_en is 1 for exactly one cycle, chosen by the latched write bit. Counter cleared. Always go to WAIT.
- WAIT: enables are 0. i_mem_ready is sampled only in WAIT, so stale ready from a previous op is never seen.
  - If i_mem_ready=1: capture i_mem_read_data into o_resp_rdata (0 for stores), set err=0, go to RESP.
  - If ready=0 and counter==TimeoutCycles-1: o_resp_rdata=0, err=1, go to RESP.
  - Otherwise: counter+1.
  - Ready and timeout in the same cycle: ready wins, err=0.
- RESP: o_resp_valid=1 for one cycle, o_resp_err valid. Go to IDLE.
- o_resp_rdata and o_resp_err hold their values until the next WAIT exit.
- Latency: accept edge E0 -> ISSUE cycle 1 -> WAIT cycle 2 (memory ready arrives) -> RESP cycle 3. o_req_ready rises again in cycle 4. Throughput is 1 request per 4 cycles.
- i_req_valid outside IDLE is ignored. Request inputs need not be held after acceptance.
- Reset during ISSUE drops the enable asynchronously before the next edge, so no memory access occurs. Reset in WAIT/RESP discards the response, with no o_resp_valid.
- Address wrap is not applicable: addresses pass through unmodified. Full 16-bit range, xFFFF legal.

Test Plan:
- Assert i_RST mid-simulation with no clock edge -> all enables, o_resp_valid, o_resp_err and o_resp_rdata are 0 immediately; o_req_ready=1.
- Store x3000<=xABCD into real memory -> o_mem_write_en high only in cycle 1 with addr x3000, data xABCD; o_resp_valid in cycle 3; err=0, rdata=0.
- Load x3000 after that store -> o_mem_read_en high 1 cycle; o_resp_valid exactly 3 cycles after accept; rdata=xABCD.
- Hold i_req_valid high continuously with alternating addresses -> accepts only on cycles 0, 4, 8; o_req_ready low in between; each response matches its request.
- Stub i_mem_ready=0, TimeoutCycles=8 -> WAIT cycles 2..9, o_resp_valid in cycle 10 with err=1 and rdata=0; next request still completes normally.
- Pulse i_RST during WAIT of a load, then release -> no o_resp_valid; o_req_ready=1 the next cycle; a following load returns correct data.

Source files
------------

// File: rtl/lc3_mem_initiator_if.sv
// rtl/lc3_mem_initiator_if.sv - CPU request/response and block-RAM strobe bundle for lc3_mem_initiator
interface lc3_mem_initiator_if #(
    parameter int AddrBusSize = 16,
    parameter int ElementSize = 16
);
    logic                   i_req_valid;
    logic                   o_req_ready;
    logic                   i_req_write;
    logic [AddrBusSize-1:0] i_req_addr;
    logic [ElementSize-1:0] i_req_wdata;
    logic                   o_resp_valid;
    logic [ElementSize-1:0] o_resp_rdata;
    logic                   o_resp_err;
    logic                   o_mem_write_en;
    logic                   o_mem_read_en;
    logic [AddrBusSize-1:0] o_mem_write_addr;
    logic [AddrBusSize-1:0] o_mem_read_addr;
    logic [ElementSize-1:0] o_mem_write_data;
    logic                   i_mem_ready;
    logic [ElementSize-1:0] i_mem_read_data;

    modport master (
        input  i_req_valid, i_req_write, i_req_addr, i_req_wdata,
        input  i_mem_ready, i_mem_read_data,
        output o_req_ready, o_resp_valid, o_resp_rdata, o_resp_err,
        output o_mem_write_en, o_mem_read_en, o_mem_write_addr, o_mem_read_addr, o_mem_write_data
    );

    modport slave (
        output i_req_valid, i_req_write, i_req_addr, i_req_wdata,
        output i_mem_ready, i_mem_read_data,
        input  o_req_ready, o_resp_valid, o_resp_rdata, o_resp_err,
        input  o_mem_write_en, o_mem_read_en, o_mem_write_addr, o_mem_read_addr, o_mem_write_data
    );
endinterface

// File: rtl/lc3_mem_initiator.sv
// rtl/lc3_mem_initiator.sv - single-request load/store bus master with bounded wait for memory ready
module lc3_mem_initiator #(
    parameter int AddrBusSize   = 16,
    parameter int ElementSize   = 16,
    parameter int TimeoutCycles = 8,
    parameter int TimeoutWidth  = 4
) (
    input  logic                i_CLK,
    input  logic                i_RST,
    lc3_mem_initiator_if.master bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [TimeoutWidth-1:0] CntLast = TimeoutWidth'(TimeoutCycles - 1);

    state_t                 state;
    state_t                 state_nxt;
    logic [AddrBusSize-1:0] addr_q,  addr_d;
    logic [ElementSize-1:0] wdata_q, wdata_d;
    logic [ElementSize-1:0] rdata_q, rdata_d;
    logic [TimeoutWidth-1:0] cnt_q, cnt_d;
    logic write_q, write_d;
    logic wr_en_q, wr_en_d;
    logic rd_en_q, rd_en_d;
    logic valid_q, valid_d;
    logic err_q,   err_d;
    logic accept;
    logic timeout;

    assign accept  = (state == IDLE) && bus.i_req_valid;
    assign timeout = (cnt_q == CntLast);

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (bus.i_mem_ready || timeout) state_nxt = RESP;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values for the registered outputs; ready outranks timeout in the same WAIT cycle.
    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        wr_en_d = 1'b0;
        rd_en_d = 1'b0;
        valid_d = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    addr_d  = bus.i_req_addr;
                    wdata_d = bus.i_req_wdata;
                    write_d = bus.i_req_write;
                    wr_en_d = bus.i_req_write;
                    rd_en_d = !bus.i_req_write;
                end
            end
            ISSUE: cnt_d = '0;
            WAIT: begin
                if (bus.i_mem_ready) begin
                    rdata_d = write_q ? '0 : bus.i_mem_read_data;
                    err_d   = 1'b0;
                    valid_d = 1'b1;
                end else if (timeout) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            wr_en_q <= wr_en_d;
            rd_en_q <= rd_en_d;
            valid_q <= valid_d;
        end
    end

    assign bus.o_req_ready      = (state == IDLE);
    assign bus.o_resp_valid     = valid_q;
    assign bus.o_resp_rdata     = rdata_q;
    assign bus.o_resp_err       = err_q;
    assign bus.o_mem_write_en   = wr_en_q;
    assign bus.o_mem_read_en    = rd_en_q;
    assign bus.o_mem_write_addr = addr_q;
    assign bus.o_mem_read_addr  = addr_q;
    assign bus.o_mem_write_data = wdata_q;

endmodule
